// File: rtl/data_demux_rx.sv
// -----------------------------------------------------------------------------
// data_demux_rx
// Receive end of the data_mux link. Takes the 32-bit link word stream, undoes
// the transmitter's bit reversal, locks onto the idle pattern, strips idle
// words and forwards payload words to an AXIS sink through a small FIFO.
// The BX0 idle variant is turned into a one-cycle orbit-sync pulse, and the
// spacing between BX0 idles is checked against orbit_length.
//
// Ports
//   clk, resetn        clock (rising edge) and synchronous active-low reset
//   axis_in_*          link word stream in; tready = FIFO not full
//   axis_out_*         payload words out; tvalid = FIFO not empty
//   idle_word          normal idle pattern (after bit reversal)
//   idle_word_BX0      BX0 idle pattern (after bit reversal)
//   orbit_length       expected accepted-word spacing of BX0 idles, 0 = off
//   fc_linkReset       drop lock and flush the FIFO
//   clear_errors       clear bx0_err_count
//   locked             link is locked onto the idle pattern
//   fc_orbitSync_out   one-cycle pulse per accepted BX0 idle while locked
//   bx0_err_count      saturating count of BX0 spacing mismatches
// -----------------------------------------------------------------------------
module data_demux_rx #(
  parameter int DATA_WIDTH         = 32,
  parameter int INPUT_REVERSE_BITS = 1,
  parameter int LOCK_COUNT         = 4,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] axis_in_tdata,
  input  logic                  axis_in_tvalid,
  output logic                  axis_in_tready,
  output logic [DATA_WIDTH-1:0] axis_out_tdata,
  output logic                  axis_out_tvalid,
  input  logic                  axis_out_tready,
  input  logic [DATA_WIDTH-1:0] idle_word,
  input  logic [DATA_WIDTH-1:0] idle_word_BX0,
  input  logic [15:0]           orbit_length,
  input  logic                  fc_linkReset,
  input  logic                  clear_errors,
  output logic                  locked,
  output logic                  fc_orbitSync_out,
  output logic [15:0]           bx0_err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = FIFO_DEPTH[CW-1:0];
  localparam logic [7:0]    LOCK_RUN   = LOCK_COUNT[7:0];

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  // Mirror a word end for end (undoes the transmitter's output reversal).
  function automatic logic [DATA_WIDTH-1:0] bit_reverse(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      r[i] = d[DATA_WIDTH-1-i];
    end
    return r;
  endfunction

  // State and counters
  state_t          state_r, state_s;
  logic [7:0]      run_r, run_s;
  logic [15:0]     orbit_cnt_r, orbit_cnt_s;
  logic            armed_r, armed_s;
  logic            sync_r, sync_s;
  logic [15:0]     err_r, err_s;
  logic            mismatch_s;

  // Input classification
  logic                  xfer_s;
  logic [DATA_WIDTH-1:0] word_s;
  logic                  is_bx0_s;
  logic                  is_idle_s;
  logic                  is_data_s;

  // FIFO
  logic [DATA_WIDTH-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]         count_r, count_s;
  logic                  tready_r, tvalid_r;
  logic                  push_s, pop_s;

  // Decode the incoming word: reverse if configured, then classify (BX0 wins).
  always_comb begin
    xfer_s    = axis_in_tvalid & tready_r;
    word_s    = axis_in_tdata;
    is_bx0_s  = 1'b0;
    is_idle_s = 1'b0;
    is_data_s = 1'b0;
    if (INPUT_REVERSE_BITS != 0) begin
      word_s = bit_reverse(axis_in_tdata);
    end else begin
      word_s = axis_in_tdata;
    end
    if (word_s == idle_word_BX0) begin
      is_bx0_s = 1'b1;
    end else if (word_s == idle_word) begin
      is_idle_s = 1'b1;
    end else begin
      is_data_s = 1'b1;
    end
  end

  // Lock FSM next state, orbit check and FIFO push decision.
  always_comb begin
    state_s     = state_r;
    run_s       = run_r;
    orbit_cnt_s = orbit_cnt_r;
    armed_s     = armed_r;
    sync_s      = 1'b0;
    push_s      = 1'b0;
    mismatch_s  = 1'b0;
    if (fc_linkReset) begin
      // Link reset overrides everything; anything transferred now is dropped.
      state_s     = ST_UNLOCKED;
      run_s       = 8'd0;
      orbit_cnt_s = 16'd0;
      armed_s     = 1'b0;
    end else begin
      case (state_r)
        ST_UNLOCKED: begin
          if (xfer_s) begin
            if (is_data_s) begin
              run_s = 8'd0;
            end else if ((run_r + 8'd1) == LOCK_RUN) begin
              // The idle completing the run is itself discarded.
              state_s = ST_LOCKED;
              run_s   = 8'd0;
            end else begin
              run_s = run_r + 8'd1;
            end
          end else begin
            run_s = run_r;
          end
        end
        ST_LOCKED: begin
          if (xfer_s) begin
            push_s = is_data_s;
            sync_s = is_bx0_s;
            if (orbit_length != 16'd0) begin
              if (is_bx0_s) begin
                // First BX0 after lock only arms; the count excludes the BX0 itself.
                if (armed_r && ((orbit_cnt_r + 16'd1) != orbit_length)) begin
                  mismatch_s = 1'b1;
                end else begin
                  mismatch_s = 1'b0;
                end
                armed_s     = 1'b1;
                orbit_cnt_s = 16'd0;
              end else begin
                orbit_cnt_s = orbit_cnt_r + 16'd1;
              end
            end else begin
              orbit_cnt_s = orbit_cnt_r;
            end
          end else begin
            push_s = 1'b0;
          end
        end
        default: begin
          state_s = ST_UNLOCKED;
        end
      endcase
    end
  end

  // Error counter: clear beats a simultaneous mismatch; saturate at all ones.
  always_comb begin
    err_s = err_r;
    if (clear_errors) begin
      err_s = 16'd0;
    end else if (mismatch_s && (err_r != 16'hFFFF)) begin
      err_s = err_r + 16'd1;
    end else begin
      err_s = err_r;
    end
  end

  // FIFO occupancy next value; a flush empties it regardless of push/pop.
  always_comb begin
    pop_s   = tvalid_r & axis_out_tready;
    count_s = count_r;
    if (fc_linkReset) begin
      count_s = {CW{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_s = count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_s = count_r;
      endcase
    end
  end

  // Control registers: FSM, counters, FIFO pointers and handshake flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= ST_UNLOCKED;
      run_r       <= 8'd0;
      orbit_cnt_r <= 16'd0;
      armed_r     <= 1'b0;
      sync_r      <= 1'b0;
      err_r       <= 16'd0;
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      tready_r    <= 1'b0;
      tvalid_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      run_r       <= run_s;
      orbit_cnt_r <= orbit_cnt_s;
      armed_r     <= armed_s;
      sync_r      <= sync_s;
      err_r       <= err_s;
      count_r     <= count_s;
      // Flags follow the next occupancy so they are exact on the next cycle.
      tready_r    <= (count_s != FULL_COUNT);
      tvalid_r    <= (count_s != {CW{1'b0}});
      if (fc_linkReset) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // FIFO storage; contents are don't-care until the occupancy covers them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= word_s;
    end
  end

  assign axis_in_tready   = tready_r;
  assign axis_out_tvalid  = tvalid_r;
  // Head word is masked while empty so stale storage never shows on the port.
  assign axis_out_tdata   = tvalid_r ? fifo_mem_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};
  assign locked           = (state_r == ST_LOCKED);
  assign fc_orbitSync_out = sync_r;
  assign bx0_err_count    = err_r;

endmodule
